mult_iterative_unit: RTL
========================

# mult_iterative_unit

Iterative radix-2 shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU operations. It sits in the execute stage and is the producer side of the MULT writeback pipe. It accepts operands plus destination info on a start strobe, computes over multiple cycles, then presents the result, `rd` and `regWrite` together with a one-cycle `MULT_ready` pulse in the form the MULT pipe consumes.

## Interface
- `DATA_WIDTH`, 32, operand/result width (W)
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `MULT_start`  in  1  request; sampled only while `busy`=0
- `mult_op`  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- `operand_a`  in  W  rs1 value
- `operand_b`  in  W  rs2 value
- `rd_decode`  in  5  destination register
- `regWrite_decode`  in  1  write-enable to forward
- `busy`  out  1  high from cycle after accept through the `MULT_ready` cycle
- `MULT_ready`  out  1  one-cycle result-valid pulse
- `ALU_result_execute`  out  W  product (selected half)
- `rd_execute`  out  5  captured `rd_decode`
- `regWrite_execute`  out  1  captured `regWrite_decode`

## Operation
- States: IDLE, CALC, SIGN, DONE.
- IDLE: if `MULT_start`, capture op, rd, regWrite. Load `mcand` (2W bits) = |a|, `mplier` (W bits) = |b|, `acc`=0, `count`=0, `neg` = sa XOR sb, then go to CALC.
- Effective signs: sa = a[W-1] for MULH and MULHSU, else 0; sb = b[W-1] for MULH only. MUL is computed unsigned (low half identical).
- Magnitude of the most negative value (0x8000_0000) is 2^(W-1), which is representable unsigned.
- CALC, each cycle: if `mplier[0]`, then `acc += mcand`. Then `mcand <<= 1`, `mplier >>= 1`, `count++`. When `count` reaches W-1 in this cycle, go to SIGN.
- SIGN: `prod` = `neg` ? -`acc` : `acc` (2W-bit two's complement). Output register = `prod[W-1:0]` for MUL, `prod[2W-1:W]` otherwise. Go to DONE.
- DONE: `MULT_ready`=1 for this cycle only, outputs valid. Go to IDLE.
- `MULT_start` while `busy`=1 (including the DONE cycle) is ignored, not queued.
- Inputs are don't-care after the accept cycle.
- Outputs hold their last value until the next DONE.
- Reset (async, any state): state=IDLE, `busy`=0, `MULT_ready`=0, `ALU_result_execute`=0, `rd_execute`=0, `regWrite_execute`=0, internal registers 0. The in-flight operation is discarded with no pulse.

## Timing
- Start sampled high in cycle 0. CALC occupies cycles 1..W, SIGN is cycle W+1, `MULT_ready` is high in cycle W+2 (cycle 34 for W=32).
- `busy` is high in cycles 1..W+2. Earliest next accept is cycle W+3, so ready pulses are never adjacent.
- `MULT_ready` and all outputs are registered; there are no combinational paths from inputs.

## Configuration
- `MULT_EARLY_OUT_EN` defined:
  - In CALC, if `mplier`==0 at the start of a cycle, skip the add and go directly to SIGN.
  - Ready cycle = min(n+3, W+2), where n = bit index of the highest set bit of |b| plus 1 (n=0 for b=0).
  - Results are identical to the non-early-out build.
- Undefined: fixed latency W+2 for every operation.

## Structure
- Shared package `mult_pkg`:
  - `mult_op` encodings (MULT_OP_MUL, MULT_OP_MULH, MULT_OP_MULHSU, MULT_OP_MULHU)
  - state enum
  - `MULT_LATENCY` = DATA_WIDTH+2
- One sub-module, `mult_sign_adjust`: combinational conditional 2W-bit negate plus half select, used in SIGN.
- Sequencer and shift-add datapath stay in the top module.

## Test plan
- MUL 7×6, W=32, early-out undefined -> `ALU_result_execute`=42, `MULT_ready` high only in cycle 34, `rd`/`regWrite` echo the captured values.
- MULH 0x80000000×0x80000000 -> 0x40000000; MUL of the same operands -> 0x00000000.
- MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF; MULHU of the same operands -> 0xFFFFFFFE; MULH -> 0x00000000.
- Start held high continuously -> accepts in cycles 0 and 35 only, ready pulses in cycles 34 and 69; operand changes during `busy` have no effect.
- `MULT_EARLY_OUT_EN` defined:
  - b=0 -> result 0, ready in cycle 3.
  - b=1, a=0xFFFFFFFF, MULHU -> result 0, ready in cycle 4.
  - b=0x80000000 -> ready in cycle 34.
- Reset asserted in cycle 10 mid-CALC -> all outputs 0 immediately, no pulse. After release, MUL 3×5 -> 15 with normal latency.

Source files
------------

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared encodings and constants for the iterative multiplier
package mult_pkg;

    localparam int MULT_DATA_WIDTH = 32;
    localparam int MULT_LATENCY    = MULT_DATA_WIDTH + 2;

    typedef enum logic [1:0] {
        MULT_OP_MUL    = 2'b00,
        MULT_OP_MULH   = 2'b01,
        MULT_OP_MULHSU = 2'b10,
        MULT_OP_MULHU  = 2'b11
    } mult_op_e;

    typedef enum logic [1:0] {
        MULT_IDLE = 2'b00,
        MULT_CALC = 2'b01,
        MULT_SIGN = 2'b10,
        MULT_DONE = 2'b11
    } mult_state_e;

endpackage

// File: rtl/mult_sign_adjust.sv
// rtl/mult_sign_adjust.sv - conditional 2W-bit negate of the magnitude product plus half select
//
// Ports:
//   acc_i     in  2W  unsigned magnitude product
//   neg_i     in  1   result sign (product of effective operand signs)
//   op_i      in  2   operation; MUL takes the low half, all others the high half
//   result_o  out W   selected half of the signed product
module mult_sign_adjust
    import mult_pkg::*;
#(
    parameter int DATA_WIDTH = MULT_DATA_WIDTH
) (
    input  logic [2*DATA_WIDTH-1:0] acc_i,
    input  logic                    neg_i,
    input  logic [1:0]              op_i,
    output logic [DATA_WIDTH-1:0]   result_o
);

    logic [2*DATA_WIDTH-1:0] prod;

    always_comb begin
        prod = neg_i ? -acc_i : acc_i;
        if (op_i == MULT_OP_MUL) begin
            result_o = prod[DATA_WIDTH-1:0];
        end else begin
            result_o = prod[2*DATA_WIDTH-1:DATA_WIDTH];
        end
    end

endmodule

// File: rtl/mult_iterative_unit.sv
// rtl/mult_iterative_unit.sv - iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU
//
// Optional feature macro: MULT_EARLY_OUT_EN (stop iterating once the multiplier is exhausted).
//
// Ports:
//   clock               in  1   rising-edge clock
//   reset               in  1   asynchronous active-low reset
//   MULT_start          in  1   request, sampled only while idle
//   mult_op             in  2   00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   operand_a           in  W   rs1 value
//   operand_b           in  W   rs2 value
//   rd_decode           in  5   destination register
//   regWrite_decode     in  1   write enable to forward
//   busy                out 1   high from the cycle after accept through the ready cycle
//   MULT_ready          out 1   one-cycle result-valid pulse
//   ALU_result_execute  out W   selected product half
//   rd_execute          out 5   captured destination register
//   regWrite_execute    out 1   captured write enable
module mult_iterative_unit
    import mult_pkg::*;
#(
    parameter int DATA_WIDTH = MULT_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  MULT_start,
    input  logic [1:0]            mult_op,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    input  logic [4:0]            rd_decode,
    input  logic                  regWrite_decode,
    output logic                  busy,
    output logic                  MULT_ready,
    output logic [DATA_WIDTH-1:0] ALU_result_execute,
    output logic [4:0]            rd_execute,
    output logic                  regWrite_execute
);

    localparam int COUNT_W = $clog2(DATA_WIDTH);
    localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(DATA_WIDTH - 1);

    mult_state_e state_q, state_d;

    // Operation context captured at accept.
    logic [1:0]              op_q, op_d;
    logic [4:0]              rd_q, rd_d;
    logic                    rw_q, rw_d;
    logic                    neg_q, neg_d;

    // Shift-add datapath.
    logic [2*DATA_WIDTH-1:0] mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*DATA_WIDTH-1:0] acc_q, acc_d;
    logic [COUNT_W-1:0]      count_q, count_d;

    // Registered outputs; they only change when a result is published.
    logic                    busy_q, busy_d;
    logic                    ready_q, ready_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic [4:0]              rd_out_q, rd_out_d;
    logic                    rw_out_q, rw_out_d;

    logic                    sa;
    logic                    sb;
    logic [DATA_WIDTH-1:0]   mag_a;
    logic [DATA_WIDTH-1:0]   mag_b;
    logic                    skip_rest;
    logic [DATA_WIDTH-1:0]   sign_result;

    mult_sign_adjust #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sign_adjust (
        .acc_i    (acc_q),
        .neg_i    (neg_q),
        .op_i     (op_q),
        .result_o (sign_result)
    );

    // Effective operand signs: MUL shares its low half with the unsigned
    // product, so it is treated as unsigned throughout.
    always_comb begin
        sa    = ((mult_op == MULT_OP_MULH) || (mult_op == MULT_OP_MULHSU)) && operand_a[DATA_WIDTH-1];
        sb    = (mult_op == MULT_OP_MULH) && operand_b[DATA_WIDTH-1];
        // Negating the most negative value yields 2^(W-1), which is the
        // correct unsigned magnitude.
        mag_a = sa ? -operand_a : operand_a;
        mag_b = sb ? -operand_b : operand_b;
    end

`ifdef MULT_EARLY_OUT_EN
    // Once every remaining multiplier bit is zero no further add can occur.
    assign skip_rest = (mplier_q == '0);
`else
    assign skip_rest = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        rw_d     = rw_q;
        neg_d    = neg_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        rw_out_d = rw_out_q;
        ready_d  = 1'b0;

        case (state_q)
            MULT_IDLE: begin
                if (MULT_start) begin
                    op_d     = mult_op;
                    rd_d     = rd_decode;
                    rw_d     = regWrite_decode;
                    neg_d    = sa ^ sb;
                    mcand_d  = {{DATA_WIDTH{1'b0}}, mag_a};
                    mplier_d = mag_b;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = MULT_CALC;
                end
            end
            MULT_CALC: begin
                if (skip_rest) begin
                    state_d = MULT_SIGN;
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q + COUNT_W'(1);
                    if (count_q == LAST_COUNT) begin
                        state_d = MULT_SIGN;
                    end
                end
            end
            MULT_SIGN: begin
                // Publish at the SIGN->DONE edge so the ready pulse and the
                // data appear together from registers.
                result_d = sign_result;
                rd_out_d = rd_q;
                rw_out_d = rw_q;
                ready_d  = 1'b1;
                state_d  = MULT_DONE;
            end
            MULT_DONE: begin
                state_d = MULT_IDLE;
            end
            default: begin
                state_d = MULT_IDLE;
            end
        endcase

        busy_d = (state_d != MULT_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= MULT_IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            rw_q     <= 1'b0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
            rw_out_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            rw_q     <= rw_d;
            neg_q    <= neg_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
            rw_out_q <= rw_out_d;
        end
    end

    assign busy               = busy_q;
    assign MULT_ready         = ready_q;
    assign ALU_result_execute = result_q;
    assign rd_execute         = rd_out_q;
    assign regWrite_execute   = rw_out_q;

endmodule
